// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory req/ack bus, stalls the EX/MEM stage while waiting, and owns MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of dropping the low address bits.
module mem_stage_lsu #(
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_load_type_mem,
    input  logic [1:0]  mem_store_type_mem,
    input  logic        wb_reg_file_mem,
    input  logic        memtoreg_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] wb_data_wb,
    output logic [4:0]  rd_wb,
    output logic        wb_reg_file_wb,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CW = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

    localparam logic [2:0] LT_LB = 3'b000, LT_LH = 3'b001, LT_LW = 3'b010,
                           LT_LBU = 3'b011, LT_LHU = 3'b100;
    localparam logic [1:0] ST_SB = 2'b00, ST_SH = 2'b01, ST_SW = 2'b10;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   wb_data_q;
    logic [4:0]    rd_q;
    logic          wb_we_q;

    logic          access, half_acc, word_acc, misalign, issue;
    logic          req, stall, abort;
    logic [1:0]    byte_off;
    logic [31:0]   shifted, load_data, store_wdata;
    logic [3:0]    store_be;

    // A store wins when both read and write are flagged, so size decoding follows the store type.
    always_comb begin
        access   = mem_read_mem | mem_write_mem;
        half_acc = 1'b0;
        word_acc = 1'b0;
        if (mem_write_mem) begin
            half_acc = (mem_store_type_mem == ST_SH);
            word_acc = (mem_store_type_mem == ST_SW);
        end else if (mem_read_mem) begin
            half_acc = (mem_load_type_mem == LT_LH) || (mem_load_type_mem == LT_LHU);
            word_acc = (mem_load_type_mem == LT_LW);
        end
        byte_off = word_acc ? 2'b00 : (half_acc ? {alu_result_mem[1], 1'b0} : alu_result_mem[1:0]);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access & ((half_acc & alu_result_mem[0]) | (word_acc & (|alu_result_mem[1:0])));
`else
    assign misalign = 1'b0;
`endif

    assign issue = access & ~misalign;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        req     = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (issue) begin
                    req = 1'b1;
                    if (!dmem_ack) begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                count_d = (count_q == {CW{1'b1}}) ? count_q : count_q + 1'b1;
                if (dmem_ack) begin
                    req     = 1'b1;
                    state_d = S_IDLE;
                end else if (DMEM_TIMEOUT != 0 && count_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shifted = dmem_rdata >> {byte_off, 3'b000};
        case (mem_load_type_mem)
            LT_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            LT_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            LT_LBU:  load_data = {24'b0, shifted[7:0]};
            LT_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        case (mem_store_type_mem)
            ST_SB: begin
                store_be    = 4'b0001 << alu_result_mem[1:0];
                store_wdata = {4{rs2_data_mem[7:0]}};
            end
            ST_SH: begin
                store_be    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{rs2_data_mem[15:0]}};
            end
            ST_SW: begin
                store_be    = 4'b1111;
                store_wdata = rs2_data_mem;
            end
            default: begin
                store_be    = 4'b0000;
                store_wdata = rs2_data_mem;
            end
        endcase
    end

    assign dmem_req     = req & ~rst;
    assign dmem_we      = mem_write_mem;
    assign dmem_addr    = {alu_result_mem[31:2], 2'b00};
    assign dmem_be      = mem_write_mem ? store_be : (mem_read_mem ? 4'b1111 : 4'b0000);
    assign dmem_wdata   = store_wdata;
    assign mem_stall    = stall & ~rst;
    assign bus_err      = abort & ~rst;
    assign misalign_err = misalign & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // MEM/WB: a stalled cycle inserts a bubble; aborted or trapped accesses never write back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q <= '0;
            rd_q      <= '0;
            wb_we_q   <= 1'b0;
        end else if (stall) begin
            wb_data_q <= '0;
            rd_q      <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            wb_data_q <= memtoreg_mem ? load_data : alu_result_mem;
            rd_q      <= rd_mem;
            wb_we_q   <= wb_reg_file_mem & ~abort & ~misalign;
        end
    end

    assign wb_data_wb     = wb_data_q;
    assign rd_wb          = rd_q;
    assign wb_reg_file_wb = wb_we_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against an instruction-level reference model.
module tb_mem_stage_lsu;
    localparam int TMO   = 4;
    localparam int NEVER = 999;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_mem, rs2_data_mem, dmem_addr, dmem_wdata, dmem_rdata, wb_data_wb;
    logic [4:0]  rd_mem, rd_wb;
    logic        mem_write_mem, mem_read_mem, wb_reg_file_mem, memtoreg_mem;
    logic [2:0]  mem_load_type_mem;
    logic [1:0]  mem_store_type_mem;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall, wb_reg_file_wb, misalign_err, bus_err;
    logic [3:0]  dmem_be;

    mem_stage_lsu #(.DMEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem), .rd_mem(rd_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
        .mem_load_type_mem(mem_load_type_mem), .mem_store_type_mem(mem_store_type_mem),
        .wb_reg_file_mem(wb_reg_file_mem), .memtoreg_mem(memtoreg_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_data_wb(wb_data_wb), .rd_wb(rd_wb),
        .wb_reg_file_wb(wb_reg_file_wb), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] addr, rs2, rdata;
        logic [4:0]  rd;
        logic        wr, rdn, wbrf, m2r;
        logic [2:0]  lt;
        logic [1:0]  st;
        int          delay;
    } instr_t;

    function automatic instr_t mk(input logic wr, input logic rdn, input logic [2:0] lt,
                                  input logic [1:0] st, input logic [31:0] addr,
                                  input logic [31:0] rs2, input logic [31:0] rdata,
                                  input logic [4:0] rd, input logic wbrf, input int delay);
        instr_t t;
        t.wr = wr; t.rdn = rdn; t.lt = lt; t.st = st; t.addr = addr; t.rs2 = rs2;
        t.rdata = rdata; t.rd = rd; t.wbrf = wbrf; t.delay = delay;
        t.m2r = rdn & ~wr;
        return t;
    endfunction

    function automatic logic mis_of(input instr_t t);
        logic half, word;
        half = 1'b0; word = 1'b0;
        if (t.wr) begin
            half = (t.st == 2'd1); word = (t.st == 2'd2);
        end else if (t.rdn) begin
            half = (t.lt == 3'd1) || (t.lt == 3'd4); word = (t.lt == 3'd2);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        return (half && t.addr[0]) || (word && (t.addr % 4) != 0);
`else
        return 1'b0 & half & word;
`endif
    endfunction

    function automatic logic [31:0] ld_model(input instr_t t);
        int          off;
        logic [31:0] w, v;
        case (t.lt)
            3'd1, 3'd4: off = (t.addr % 4) & 2;
            3'd2:       off = 0;
            default:    off = t.addr % 4;
        endcase
        w = t.rdata >> (8 * off);
        case (t.lt)
            3'd0: begin v = w % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = w % 65536; if (v >= 32768) v = v - 65536; end
            3'd3: v = w % 256;
            3'd4: v = w % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] be_model(input instr_t t);
        if (!t.wr) return 4'hF;
        case (t.st)
            2'd0: return 4'(1 << (t.addr % 4));
            2'd1: return ((t.addr % 4) >= 2) ? 4'hC : 4'h3;
            2'd2: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] wd_model(input instr_t t);
        case (t.st)
            2'd0: return (t.rs2 % 256) * 32'h0101_0101;
            2'd1: return (t.rs2 % 65536) * 32'h0001_0001;
            default: return t.rs2;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the edge that retires the instruction.
    task automatic run_instr(input instr_t t);
        int   idx;
        logic done, pend, mis, ack, abort, stall_e, req_e;
        logic [31:0] e_data; logic [4:0] e_rd; logic e_we;
        alu_result_mem = t.addr; rs2_data_mem = t.rs2; rd_mem = t.rd;
        mem_write_mem = t.wr; mem_read_mem = t.rdn; mem_load_type_mem = t.lt;
        mem_store_type_mem = t.st; wb_reg_file_mem = t.wbrf; memtoreg_mem = t.m2r;
        mis  = mis_of(t);
        pend = (t.wr | t.rdn) & ~mis;
        idx  = 0;
        done = 1'b0;
        while (!done) begin
            ack = pend && (idx == t.delay);
            dmem_ack = ack; dmem_rdata = t.rdata;
            #2;
            abort   = pend && !ack && (TMO != 0) && (idx == TMO);
            req_e   = pend && !abort;
            stall_e = pend && !ack && !abort;
            check("req", dmem_req, req_e);
            check("stall", mem_stall, stall_e);
            check("bus_err", bus_err, abort);
            check("misalign_err", misalign_err, mis);
            if (req_e) begin
                check("we", dmem_we, t.wr);
                check("addr", dmem_addr, t.addr & 32'hFFFF_FFFC);
                check("be", dmem_be, be_model(t));
                if (t.wr && t.st != 2'd3) check("wdata", dmem_wdata, wd_model(t));
            end
            if (stall_e) begin
                e_data = 0; e_rd = 0; e_we = 0;
            end else begin
                e_data = t.m2r ? ld_model(t) : t.addr;
                e_rd   = t.rd;
                e_we   = t.wbrf && !abort && !mis;
            end
            @(posedge clk); #1;
            check("wb_data", wb_data_wb, e_data);
            check("rd_wb", rd_wb, e_rd);
            check("wb_we", wb_reg_file_wb, e_we);
            done = !stall_e;
            idx++;
            if (!done && idx > 50) begin
                n_tests++; n_fail++;
                $display("FAIL bound: stall still %b after %0d cycles", mem_stall, idx);
                done = 1'b1;
            end
        end
        dmem_ack = 1'b0;
    endtask

    function automatic instr_t rand_instr();
        instr_t t;
        int kind, r;
        logic [2:0] lts [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        kind = $urandom_range(0, 2);
        r = $urandom_range(0, 9);
        t = mk(0, 0, 3'd7, 2'd3, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
               (r < 6) ? r : ((r < 8) ? 0 : NEVER));
        if (kind == 1) begin
            t.rdn = 1; t.lt = lts[$urandom_range(0, 4)]; t.m2r = 1;
        end else if (kind == 2) begin
            t.wr = 1; t.st = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                t.rdn = 1; t.lt = lts[$urandom_range(0, 4)];
            end
        end
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        alu_result_mem = 32'h200; rs2_data_mem = 0; rd_mem = 5'd3;
        mem_write_mem = 0; mem_read_mem = 1; mem_load_type_mem = 3'd2; mem_store_type_mem = 2'd3;
        wb_reg_file_mem = 1; memtoreg_mem = 1; dmem_ack = 0; dmem_rdata = 0;
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_data", wb_data_wb, 0);
        check("rst_rd", rd_wb, 0);
        check("rst_we", wb_reg_file_wb, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_instr(mk(1, 0, 3'd7, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 5'd1, 0, 0));
        run_instr(mk(0, 1, 3'd0, 2'd3, 32'h203, 32'h0, 32'h80123456, 5'd2, 1, 3));
        run_instr(mk(0, 1, 3'd4, 2'd3, 32'h202, 32'h0, 32'hBEEF1234, 5'd4, 1, 1));
        run_instr(mk(1, 0, 3'd7, 2'd0, 32'h1, 32'hAB, 32'h0, 5'd5, 0, 0));
        run_instr(mk(0, 1, 3'd2, 2'd3, 32'h300, 32'h0, 32'h12345678, 5'd6, 1, NEVER));
        run_instr(mk(0, 0, 3'd7, 2'd3, 32'h55AA, 32'h0, 32'h0, 5'd7, 1, 0));
        run_instr(mk(0, 1, 3'd2, 2'd3, 32'h102, 32'h0, 32'hCAFEF00D, 5'd8, 1, 0));
        run_instr(mk(1, 0, 3'd7, 2'd1, 32'h103, 32'h1234BEEF, 32'h0, 5'd9, 0, 2));
        run_instr(mk(0, 1, 3'd1, 2'd3, 32'h2, 32'h0, 32'h8001_7FFF, 5'd10, 1, 4));

        for (int i = 0; i < 150; i++) run_instr(rand_instr());

        // Reset while a load sits in WAIT.
        alu_result_mem = 32'h400; mem_write_mem = 0; mem_read_mem = 1; mem_load_type_mem = 3'd2;
        rd_mem = 5'd11; wb_reg_file_mem = 1; memtoreg_mem = 1; dmem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("pre_rst_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_stall", mem_stall, 0);
        check("mid_rst_bus_err", bus_err, 0);
        check("mid_rst_wb_data", wb_data_wb, 0);
        check("mid_rst_rd", rd_wb, 0);
        check("mid_rst_we", wb_reg_file_wb, 0);
        mem_read_mem = 0;
        @(posedge clk); #1 rst = 1'b0;
        run_instr(mk(0, 1, 3'd2, 2'd3, 32'h400, 32'h0, 32'h0BAD_BEEF, 5'd11, 1, 2));
        run_instr(mk(0, 1, 3'd3, 2'd3, 32'h401, 32'h0, 32'h0000_F100, 5'd12, 1, TMO));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
